// File: rtl/vx_fpu_req_sequencer_if.sv
// Request/batch bundle between the issue-stage FPU dispatch ports, the
// sequencer and the narrow FPU datapath.
interface vx_fpu_req_sequencer_if #(
    parameter int NUM_REQS      = 4,
    parameter int NUM_THREADS   = 4,
    parameter int NUM_LANES     = 2,
    parameter int UUID_BITS     = 44,
    parameter int NW_BITS       = 2,
    parameter int INST_FPU_BITS = 4,
    parameter int INST_MOD_BITS = 3,
    parameter int NR_BITS       = 5
);
    localparam int BATCHES    = NUM_THREADS / NUM_LANES;
    localparam int BATCH_BITS = (BATCHES > 1) ? $clog2(BATCHES) : 1;
    localparam int REQ_BITS   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    logic [NUM_REQS-1:0]                        req_valid;
    logic [NUM_REQS-1:0][UUID_BITS-1:0]         req_uuid;
    logic [NUM_REQS-1:0][NW_BITS-1:0]           req_wid;
    logic [NUM_REQS-1:0][31:0]                  req_PC;
    logic [NUM_REQS-1:0][INST_FPU_BITS-1:0]     req_op_type;
    logic [NUM_REQS-1:0][INST_MOD_BITS-1:0]     req_op_mod;
    logic [NUM_REQS-1:0][NR_BITS-1:0]           req_rd;
    logic [NUM_REQS-1:0]                        req_wb;
    logic [NUM_REQS-1:0][NUM_THREADS-1:0]       req_tmask;
    logic [NUM_REQS-1:0][NUM_THREADS-1:0][31:0] req_rs1_data;
    logic [NUM_REQS-1:0][NUM_THREADS-1:0][31:0] req_rs2_data;
    logic [NUM_REQS-1:0][NUM_THREADS-1:0][31:0] req_rs3_data;
    logic [NUM_REQS-1:0]                        req_ready;

    logic                                       out_valid;
    logic [UUID_BITS-1:0]                       out_uuid;
    logic [NW_BITS-1:0]                         out_wid;
    logic [31:0]                                out_PC;
    logic [INST_FPU_BITS-1:0]                   out_op_type;
    logic [INST_MOD_BITS-1:0]                   out_op_mod;
    logic [NR_BITS-1:0]                         out_rd;
    logic                                       out_wb;
    logic [NUM_LANES-1:0]                       out_tmask;
    logic [NUM_LANES-1:0][31:0]                 out_rs1_data;
    logic [NUM_LANES-1:0][31:0]                 out_rs2_data;
    logic [NUM_LANES-1:0][31:0]                 out_rs3_data;
    logic [REQ_BITS-1:0]                        out_req_idx;
    logic [BATCH_BITS-1:0]                      out_batch_idx;
    logic                                       out_last;
    logic                                       out_ready;

    modport slave (
        input  req_valid, req_uuid, req_wid, req_PC, req_op_type, req_op_mod,
               req_rd, req_wb, req_tmask, req_rs1_data, req_rs2_data, req_rs3_data,
               out_ready,
        output req_ready,
               out_valid, out_uuid, out_wid, out_PC, out_op_type, out_op_mod,
               out_rd, out_wb, out_tmask, out_rs1_data, out_rs2_data, out_rs3_data,
               out_req_idx, out_batch_idx, out_last
    );

    modport master (
        output req_valid, req_uuid, req_wid, req_PC, req_op_type, req_op_mod,
               req_rd, req_wb, req_tmask, req_rs1_data, req_rs2_data, req_rs3_data,
               out_ready,
        input  req_ready,
               out_valid, out_uuid, out_wid, out_PC, out_op_type, out_op_mod,
               out_rd, out_wb, out_tmask, out_rs1_data, out_rs2_data, out_rs3_data,
               out_req_idx, out_batch_idx, out_last
    );
endinterface

// File: rtl/vx_fpu_req_sequencer.sv
// Round-robin FPU request arbiter that holds the winner and replays it as
// NUM_LANES-wide batches, skipping batches whose thread-mask slice is empty.
module vx_fpu_req_sequencer #(
    parameter int NUM_REQS      = 4,
    parameter int NUM_THREADS   = 4,
    parameter int NUM_LANES     = 2,
    parameter int UUID_BITS     = 44,
    parameter int NW_BITS       = 2,
    parameter int INST_FPU_BITS = 4,
    parameter int INST_MOD_BITS = 3,
    parameter int NR_BITS       = 5
) (
    input  logic                       clk,
    input  logic                       reset_n,
    vx_fpu_req_sequencer_if.slave      seq_if
);
    localparam int BATCHES    = NUM_THREADS / NUM_LANES;
    localparam int BATCH_BITS = (BATCHES > 1) ? $clog2(BATCHES) : 1;
    localparam int REQ_BITS   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t                               r_state, w_state_next;
    logic [REQ_BITS-1:0]                  r_rr, w_rr_next, w_grant_idx, w_rr_inc;
    logic                                 w_grant_valid;
    logic [BATCH_BITS-1:0]                r_cursor, w_cursor_next, w_cur, w_next_batch;
    logic                                 w_last, w_fire, w_accept;
    logic [BATCHES-1:0]                   w_slice_nz;

    logic [REQ_BITS-1:0]                  r_req_idx;
    logic [UUID_BITS-1:0]                 r_uuid;
    logic [NW_BITS-1:0]                   r_wid;
    logic [31:0]                          r_pc;
    logic [INST_FPU_BITS-1:0]             r_op_type;
    logic [INST_MOD_BITS-1:0]             r_op_mod;
    logic [NR_BITS-1:0]                   r_rd;
    logic                                 r_wb;
    // Held per batch so the cursor indexes a slice directly.
    logic [BATCHES-1:0][NUM_LANES-1:0]        r_tmask;
    logic [BATCHES-1:0][NUM_LANES-1:0][31:0]  r_rs1, r_rs2, r_rs3;

    for (genvar gi = 0; gi < BATCHES; gi++) begin : g_slice
        assign w_slice_nz[gi] = |r_tmask[gi];
    end

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            int c;
            c = (int'(r_rr) + i) % NUM_REQS;
            if (!w_grant_valid && seq_if.req_valid[c]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = REQ_BITS'(c);
            end
        end
        w_rr_inc = (w_grant_idx == REQ_BITS'(NUM_REQS - 1)) ? '0 : w_grant_idx + 1'b1;
    end

    // A zero mask finds no slice and falls back to batch 0 flagged last.
    always_comb begin
        logic found_cur, found_nxt;
        found_cur    = 1'b0;
        found_nxt    = 1'b0;
        w_cur        = '0;
        w_next_batch = '0;
        w_last       = 1'b1;
        for (int b = 0; b < BATCHES; b++) begin
            if (!found_cur && b >= int'(r_cursor) && w_slice_nz[b]) begin
                found_cur = 1'b1;
                w_cur     = BATCH_BITS'(b);
            end
        end
        for (int b = 0; b < BATCHES; b++) begin
            if (!found_nxt && b > int'(w_cur) && w_slice_nz[b]) begin
                found_nxt    = 1'b1;
                w_next_batch = BATCH_BITS'(b);
                w_last       = 1'b0;
            end
        end
    end

    assign w_fire   = (r_state == S_BUSY) && seq_if.out_ready;
    assign w_accept = w_grant_valid && ((r_state == S_IDLE) || (w_fire && w_last));

    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_ready
        assign seq_if.req_ready[gi] = reset_n && w_accept && (w_grant_idx == REQ_BITS'(gi));
    end

    always_comb begin
        w_state_next  = r_state;
        w_rr_next     = r_rr;
        w_cursor_next = r_cursor;
        if (w_accept) begin
            w_state_next  = S_BUSY;
            w_rr_next     = w_rr_inc;
            w_cursor_next = '0;
        end else if (w_fire && w_last) begin
            w_state_next  = S_IDLE;
        end else if (w_fire) begin
            w_cursor_next = w_next_batch;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_rr     <= '0;
            r_cursor <= '0;
        end else begin
            r_state  <= w_state_next;
            r_rr     <= w_rr_next;
            r_cursor <= w_cursor_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_req_idx <= '0;
            r_uuid    <= '0;
            r_wid     <= '0;
            r_pc      <= '0;
            r_op_type <= '0;
            r_op_mod  <= '0;
            r_rd      <= '0;
            r_wb      <= 1'b0;
            r_tmask   <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rs3     <= '0;
        end else if (w_accept) begin
            r_req_idx <= w_grant_idx;
            r_uuid    <= seq_if.req_uuid[w_grant_idx];
            r_wid     <= seq_if.req_wid[w_grant_idx];
            r_pc      <= seq_if.req_PC[w_grant_idx];
            r_op_type <= seq_if.req_op_type[w_grant_idx];
            r_op_mod  <= seq_if.req_op_mod[w_grant_idx];
            r_rd      <= seq_if.req_rd[w_grant_idx];
            r_wb      <= seq_if.req_wb[w_grant_idx];
            r_tmask   <= seq_if.req_tmask[w_grant_idx];
            r_rs1     <= seq_if.req_rs1_data[w_grant_idx];
            r_rs2     <= seq_if.req_rs2_data[w_grant_idx];
            r_rs3     <= seq_if.req_rs3_data[w_grant_idx];
        end
    end

    assign seq_if.out_valid     = (r_state == S_BUSY);
    assign seq_if.out_uuid      = r_uuid;
    assign seq_if.out_wid       = r_wid;
    assign seq_if.out_PC        = r_pc;
    assign seq_if.out_op_type   = r_op_type;
    assign seq_if.out_op_mod    = r_op_mod;
    assign seq_if.out_rd        = r_rd;
    assign seq_if.out_wb        = r_wb;
    assign seq_if.out_tmask     = r_tmask[w_cur];
    assign seq_if.out_rs1_data  = r_rs1[w_cur];
    assign seq_if.out_rs2_data  = r_rs2[w_cur];
    assign seq_if.out_rs3_data  = r_rs3[w_cur];
    assign seq_if.out_req_idx   = r_req_idx;
    assign seq_if.out_batch_idx = w_cur;
    assign seq_if.out_last      = w_last;
endmodule

// File: tb/tb_vx_fpu_req_sequencer.sv
// Directed bench for vx_fpu_req_sequencer: arbitration order, batch skipping,
// zero masks, back-to-back accept, backpressure and asynchronous reset.
module tb_vx_fpu_req_sequencer;
    localparam int NUM_REQS    = 4;
    localparam int NUM_THREADS = 4;
    localparam int NUM_LANES   = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    vx_fpu_req_sequencer_if #(
        .NUM_REQS(NUM_REQS), .NUM_THREADS(NUM_THREADS), .NUM_LANES(NUM_LANES)
    ) sif ();

    vx_fpu_req_sequencer #(
        .NUM_REQS(NUM_REQS), .NUM_THREADS(NUM_THREADS), .NUM_LANES(NUM_LANES)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .seq_if  (sif.slave)
    );

    function automatic logic [31:0] dval(input int op, input int c, input int t);
        return 32'((op << 24) | (c << 8) | t);
    endfunction

    task automatic set_chan(input int c, input logic [3:0] tm, input logic [4:0] rd, input logic wb);
        sif.req_tmask[c]   = tm;
        sif.req_rd[c]      = rd;
        sif.req_wb[c]      = wb;
        sif.req_uuid[c]    = 44'(c + 100);
        sif.req_wid[c]     = 2'(c);
        sif.req_PC[c]      = 32'h8000_0000 + 32'(c * 4);
        sif.req_op_type[c] = 4'(c);
        sif.req_op_mod[c]  = 3'(c);
        for (int t = 0; t < NUM_THREADS; t++) begin
            sif.req_rs1_data[c][t] = dval(1, c, t);
            sif.req_rs2_data[c][t] = dval(2, c, t);
            sif.req_rs3_data[c][t] = dval(3, c, t);
        end
    endtask

    task automatic test_reset();
        sif.req_valid = 4'b1111;
        sif.out_ready = 1'b1;
        for (int c = 0; c < NUM_REQS; c++) set_chan(c, 4'b1111, 5'(c + 1), 1'b1);
        #1;
        checks++; if (sif.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", sif.req_ready); end
        checks++; if (sif.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", sif.out_valid); end
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        sif.req_valid = 4'b0000;
        #1;
        checks++; if (sif.out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_out_valid got=%b exp=0", sif.out_valid); end
        checks++; if (sif.req_ready !== 4'b0000) begin failures++; $display("FAIL post_reset_req_ready got=%b exp=0000", sif.req_ready); end
        checks++; if (sif.out_rd !== 5'd0) begin failures++; $display("FAIL post_reset_held_rd got=%0d exp=0", sif.out_rd); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        @(negedge clk);
        set_chan(2, 4'b1100, 5'd9, 1'b1);
        sif.req_valid = 4'b0100;
        #1;
        checks++; if (sif.req_ready !== 4'b0100) begin failures++; $display("FAIL single_req_ready got=%b exp=0100", sif.req_ready); end
        @(negedge clk);
        sif.req_valid = 4'b0000;
        #1;
        checks++; if (sif.out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got=%b exp=1", sif.out_valid); end
        checks++; if (sif.out_batch_idx !== 1'b1) begin failures++; $display("FAIL single_batch_idx got=%0d exp=1", sif.out_batch_idx); end
        checks++; if (sif.out_tmask !== 2'b11) begin failures++; $display("FAIL single_tmask got=%b exp=11", sif.out_tmask); end
        checks++; if (sif.out_last !== 1'b1) begin failures++; $display("FAIL single_last got=%b exp=1", sif.out_last); end
        checks++; if (sif.out_req_idx !== 2'd2) begin failures++; $display("FAIL single_req_idx got=%0d exp=2", sif.out_req_idx); end
        checks++; if (sif.out_rs1_data[0] !== dval(1, 2, 2)) begin failures++; $display("FAIL single_rs1_lane0 got=%h exp=%h", sif.out_rs1_data[0], dval(1, 2, 2)); end
        checks++; if (sif.out_rs2_data[1] !== dval(2, 2, 3)) begin failures++; $display("FAIL single_rs2_lane1 got=%h exp=%h", sif.out_rs2_data[1], dval(2, 2, 3)); end
        checks++; if (sif.out_rd !== 5'd9) begin failures++; $display("FAIL single_rd got=%0d exp=9", sif.out_rd); end
        @(negedge clk);
        #1;
        checks++; if (sif.out_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", sif.out_valid); end
        $display("test_single done");
    endtask

    // rr is 3 here: full-mask request on channel 3, then a zero-mask one on channel 0.
    task automatic test_back_to_back();
        @(negedge clk);
        set_chan(3, 4'b1111, 5'd12, 1'b0);
        sif.req_valid = 4'b1000;
        #1;
        checks++; if (sif.req_ready !== 4'b1000) begin failures++; $display("FAIL b2b_req_ready got=%b exp=1000", sif.req_ready); end
        @(negedge clk);
        set_chan(0, 4'b0000, 5'd7, 1'b1);
        sif.req_valid = 4'b0001;
        #1;
        checks++; if (sif.out_valid !== 1'b1 || sif.out_batch_idx !== 1'b0 || sif.out_last !== 1'b0) begin failures++; $display("FAIL b2b_batch0 got=v%b i%0d l%b exp=v1 i0 l0", sif.out_valid, sif.out_batch_idx, sif.out_last); end
        checks++; if (sif.out_rs1_data[1] !== dval(1, 3, 1)) begin failures++; $display("FAIL b2b_batch0_rs1 got=%h exp=%h", sif.out_rs1_data[1], dval(1, 3, 1)); end
        checks++; if (sif.req_ready !== 4'b0000) begin failures++; $display("FAIL b2b_busy_ready got=%b exp=0000", sif.req_ready); end
        @(negedge clk);
        #1;
        checks++; if (sif.out_valid !== 1'b1 || sif.out_batch_idx !== 1'b1 || sif.out_last !== 1'b1) begin failures++; $display("FAIL b2b_batch1 got=v%b i%0d l%b exp=v1 i1 l1", sif.out_valid, sif.out_batch_idx, sif.out_last); end
        checks++; if (sif.out_rs3_data[0] !== dval(3, 3, 2)) begin failures++; $display("FAIL b2b_batch1_rs3 got=%h exp=%h", sif.out_rs3_data[0], dval(3, 3, 2)); end
        checks++; if (sif.req_ready !== 4'b0001) begin failures++; $display("FAIL b2b_same_cycle_accept got=%b exp=0001", sif.req_ready); end
        @(negedge clk);
        sif.req_valid = 4'b0000;
        #1;
        checks++; if (sif.out_valid !== 1'b1 || sif.out_req_idx !== 2'd0) begin failures++; $display("FAIL zero_mask_valid got=v%b r%0d exp=v1 r0", sif.out_valid, sif.out_req_idx); end
        checks++; if (sif.out_batch_idx !== 1'b0 || sif.out_tmask !== 2'b00 || sif.out_last !== 1'b1) begin failures++; $display("FAIL zero_mask_batch got=i%0d m%b l%b exp=i0 m00 l1", sif.out_batch_idx, sif.out_tmask, sif.out_last); end
        checks++; if (sif.out_rd !== 5'd7 || sif.out_wb !== 1'b1) begin failures++; $display("FAIL zero_mask_rd_wb got=rd%0d wb%b exp=rd7 wb1", sif.out_rd, sif.out_wb); end
        @(negedge clk);
        #1;
        checks++; if (sif.out_valid !== 1'b0) begin failures++; $display("FAIL zero_mask_single got=%b exp=0", sif.out_valid); end
        $display("test_back_to_back done");
    endtask

    // rr is 1 here, so with every channel valid the grants go 1,2,3,0,1.
    task automatic test_round_robin();
        int exp_order[5] = '{1, 2, 3, 0, 1};
        logic [3:0] exp_ready;
        @(negedge clk);
        for (int c = 0; c < NUM_REQS; c++) set_chan(c, 4'b0001, 5'(c + 20), 1'b1);
        sif.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            exp_ready = 4'b0001 << exp_order[k];
            checks++; if (sif.req_ready !== exp_ready) begin failures++; $display("FAIL rr_grant_%0d got=%b exp=%b", k, sif.req_ready, exp_ready); end
            if (k > 0) begin
                checks++; if (sif.out_valid !== 1'b1 || sif.out_req_idx !== 2'(exp_order[k-1])) begin failures++; $display("FAIL rr_out_%0d got=v%b r%0d exp=v1 r%0d", k, sif.out_valid, sif.out_req_idx, exp_order[k-1]); end
            end
        end
        @(negedge clk);
        sif.req_valid = 4'b0000;
        #1;
        checks++; if (sif.out_req_idx !== 2'd1 || sif.out_last !== 1'b1 || sif.out_rd !== 5'd21) begin failures++; $display("FAIL rr_final got=r%0d l%b rd%0d exp=r1 l1 rd21", sif.out_req_idx, sif.out_last, sif.out_rd); end
        @(negedge clk);
        #1;
        checks++; if (sif.out_valid !== 1'b0) begin failures++; $display("FAIL rr_drain got=%b exp=0", sif.out_valid); end
        $display("test_round_robin done");
    endtask

    // rr is 2 here: channel 2 full mask stalled 3 cycles, channel 3 waiting behind it.
    task automatic test_backpressure();
        @(negedge clk);
        set_chan(2, 4'b1111, 5'd3, 1'b1);
        set_chan(3, 4'b0010, 5'd4, 1'b0);
        sif.req_valid = 4'b0100;
        #1;
        checks++; if (sif.req_ready !== 4'b0100) begin failures++; $display("FAIL bp_accept got=%b exp=0100", sif.req_ready); end
        @(negedge clk);
        sif.out_ready = 1'b0;
        sif.req_valid = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            checks++; if (sif.out_valid !== 1'b1 || sif.out_batch_idx !== 1'b0 || sif.out_last !== 1'b0) begin failures++; $display("FAIL bp_hold_%0d got=v%b i%0d l%b exp=v1 i0 l0", k, sif.out_valid, sif.out_batch_idx, sif.out_last); end
            checks++; if (sif.out_rs3_data[1] !== dval(3, 2, 1)) begin failures++; $display("FAIL bp_hold_data_%0d got=%h exp=%h", k, sif.out_rs3_data[1], dval(3, 2, 1)); end
            checks++; if (sif.req_ready !== 4'b0000) begin failures++; $display("FAIL bp_hold_ready_%0d got=%b exp=0000", k, sif.req_ready); end
        end
        @(negedge clk);
        sif.out_ready = 1'b1;
        #1;
        checks++; if (sif.out_batch_idx !== 1'b0 || sif.req_ready !== 4'b0000) begin failures++; $display("FAIL bp_resume0 got=i%0d rdy%b exp=i0 rdy0000", sif.out_batch_idx, sif.req_ready); end
        @(negedge clk);
        #1;
        checks++; if (sif.out_batch_idx !== 1'b1 || sif.out_last !== 1'b1 || sif.out_rs1_data[0] !== dval(1, 2, 2)) begin failures++; $display("FAIL bp_resume1 got=i%0d l%b d%h exp=i1 l1 d%h", sif.out_batch_idx, sif.out_last, sif.out_rs1_data[0], dval(1, 2, 2)); end
        checks++; if (sif.req_ready !== 4'b1000) begin failures++; $display("FAIL bp_next_accept got=%b exp=1000", sif.req_ready); end
        @(negedge clk);
        sif.req_valid = 4'b0000;
        #1;
        checks++; if (sif.out_req_idx !== 2'd3 || sif.out_batch_idx !== 1'b0 || sif.out_tmask !== 2'b10 || sif.out_last !== 1'b1) begin failures++; $display("FAIL bp_ch3 got=r%0d i%0d m%b l%b exp=r3 i0 m10 l1", sif.out_req_idx, sif.out_batch_idx, sif.out_tmask, sif.out_last); end
        checks++; if (sif.out_rs1_data[1] !== dval(1, 3, 1)) begin failures++; $display("FAIL bp_ch3_data got=%h exp=%h", sif.out_rs1_data[1], dval(1, 3, 1)); end
        @(negedge clk);
        #1;
        checks++; if (sif.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", sif.out_valid); end
        $display("test_backpressure done");
    endtask

    // rr reaches 2 after accepting channel 1; after reset, channels 0 and 3
    // both valid must grant channel 0, showing rr restarted.
    task automatic test_reset_mid();
        @(negedge clk);
        set_chan(1, 4'b1111, 5'd15, 1'b1);
        sif.req_valid = 4'b0010;
        #1;
        checks++; if (sif.req_ready !== 4'b0010) begin failures++; $display("FAIL rst_mid_accept got=%b exp=0010", sif.req_ready); end
        @(negedge clk);
        sif.req_valid = 4'b0000;
        #1;
        checks++; if (sif.out_valid !== 1'b1 || sif.out_batch_idx !== 1'b0) begin failures++; $display("FAIL rst_mid_batch0 got=v%b i%0d exp=v1 i0", sif.out_valid, sif.out_batch_idx); end
        #1;
        reset_n = 1'b0;
        sif.req_valid = 4'b1111;
        #1;
        checks++; if (sif.out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_async_valid got=%b exp=0", sif.out_valid); end
        checks++; if (sif.req_ready !== 4'b0000) begin failures++; $display("FAIL rst_mid_ready got=%b exp=0000", sif.req_ready); end
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        set_chan(0, 4'b0001, 5'd30, 1'b1);
        sif.req_valid = 4'b1001;
        #1;
        checks++; if (sif.out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_discard got=%b exp=0", sif.out_valid); end
        checks++; if (sif.req_ready !== 4'b0001) begin failures++; $display("FAIL rst_mid_rr_restart got=%b exp=0001", sif.req_ready); end
        @(negedge clk);
        sif.req_valid = 4'b0000;
        #1;
        checks++; if (sif.out_valid !== 1'b1 || sif.out_req_idx !== 2'd0 || sif.out_rd !== 5'd30) begin failures++; $display("FAIL rst_mid_after got=v%b r%0d rd%0d exp=v1 r0 rd30", sif.out_valid, sif.out_req_idx, sif.out_rd); end
        @(negedge clk);
        #1;
        checks++; if (sif.out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_drain got=%b exp=0", sif.out_valid); end
        $display("test_reset_mid done");
    endtask

    initial begin
        sif.req_valid    = '0;
        sif.req_uuid     = '0;
        sif.req_wid      = '0;
        sif.req_PC       = '0;
        sif.req_op_type  = '0;
        sif.req_op_mod   = '0;
        sif.req_rd       = '0;
        sif.req_wb       = '0;
        sif.req_tmask    = '0;
        sif.req_rs1_data = '0;
        sif.req_rs2_data = '0;
        sif.req_rs3_data = '0;
        sif.out_ready    = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vx_fpu_req_sequencer.md
# vx_fpu_req_sequencer

Multi-source FPU request sequencer between the issue stage's per-slice FPU dispatch ports and a narrow FPU datapath. It round-robin arbitrates among `NUM_REQS` FPU request channels and registers the winning request. It then replays that request to the FPU as one or more lane batches of `NUM_LANES` threads, skipping batches whose thread-mask slice is empty. Each batch carries its source index, batch index and last flag so the response path can reassemble per-warp results.

## Interface
Parameters:
- `NUM_REQS`, 4: number of request channels; ≥1.
- `NUM_THREADS`, 4: threads per request.
- `NUM_LANES`, 2: threads per output batch. `NUM_THREADS % NUM_LANES == 0` is required.
- `BATCHES`, derived = `NUM_THREADS/NUM_LANES`. `BATCH_BITS` = max(1, clog2(`BATCHES`)). `REQ_BITS` = max(1, clog2(`NUM_REQS`)).

Ports (clock and reset first):
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  [NUM_REQS]  per-channel request valid.
- `req_uuid`, `req_wid`, `req_PC`, `req_op_type`, `req_op_mod`, `req_rd`, `req_wb`  in  [NUM_REQS][`UUID_BITS`/`NW_BITS`/32/`INST_FPU_BITS`/`INST_MOD_BITS`/`NR_BITS`/1]  per-channel request fields.
- `req_tmask`  in  [NUM_REQS][NUM_THREADS]  per-channel thread mask.
- `req_rs1_data`, `req_rs2_data`, `req_rs3_data`  in  [NUM_REQS][NUM_THREADS][32]  operands.
- `req_ready`  out  [NUM_REQS]  per-channel accept; one-hot or zero.
- `out_valid`  out  1  batch valid.
- `out_uuid`, `out_wid`, `out_PC`, `out_op_type`, `out_op_mod`, `out_rd`, `out_wb`  out  same widths  copied from the held request.
- `out_tmask`  out  [NUM_LANES]  mask slice for this batch.
- `out_rs1_data`, `out_rs2_data`, `out_rs3_data`  out  [NUM_LANES][32]  operand slices.
- `out_req_idx`  out  REQ_BITS  source channel.
- `out_batch_idx`  out  BATCH_BITS  batch number; lanes cover threads `batch*NUM_LANES ..`.
- `out_last`  out  1  final batch of this request.
- `out_ready`  in  1  FPU accept.

## Operation
- Holding register plus FSM with two states:
  - IDLE: holding register empty.
  - BUSY: a request is held and is being emitted.
- Arbitration:
  - Round-robin pointer `rr`. Grant goes to the first valid channel at or after `rr`, modulo `NUM_REQS`.
  - `req_ready[g]` = grant_valid && (state==IDLE || (out_valid && out_ready && out_last)).
  - On accept: latch all fields of channel g, set `rr` = (g+1) mod `NUM_REQS`, go to BUSY.
  - If the last batch fires with no grant available, go to IDLE.
- Batch selection:
  - The current batch is the lowest batch index ≥ the batch cursor whose mask slice is non-zero.
  - `out_last` = no non-zero slice exists above the current batch.
  - On `out_valid && out_ready && !out_last`, the cursor moves to the next non-zero slice.
- Zero mask (`req_tmask`==0): emit exactly one batch with `out_batch_idx`=0, `out_tmask`=0, `out_last`=1, so writeback/commit still sees the instruction.
- Data outputs are driven from the held request and the cursor. `out_*` fields other than the handshake are don't-care while `out_valid`=0, but are held at the latched values.
- Backpressure: while `out_valid && !out_ready`, all `out_*` stay stable and `req_ready` is all-zero.
- Reset (asynchronous, any time including mid-request):
  - `out_valid`=0, state IDLE, `rr`=0, cursor 0, all held data zero.
  - `req_ready` = 0 while `reset_n`=0.
  - A partially emitted request is discarded.

## Timing
- Accept at edge T gives `out_valid` at T+1, with the first non-empty batch.
- A request with k non-empty slices (k=1 for a zero mask) occupies k output cycles when `out_ready`=1.
- The next request is accepted in the same cycle the last batch fires, so there are no bubbles. Sustained throughput is 1 batch per cycle.
- Arbitration-to-`req_ready` is combinational. There is no combinational path from `req_valid` to `out_valid`.

## Test plan
- Single request, channel 2, tmask 4'b1100, `out_ready`=1 → one batch next cycle: idx=1, out_tmask=2'b11, last=1, req_idx=2, lanes = rs data of threads 2,3.
- tmask 4'b1111 → two consecutive batches, idx 0 then 1, last 0 then 1. The next request is accepted in the second cycle with no gap.
- Zero tmask → one batch: idx=0, out_tmask=2'b00, last=1, rd/wb preserved.
- All four channels valid and held → grants in order 0,1,2,3,0. `rr` wraps, and each `req_ready` is one-hot.
- `out_ready` held low for 3 cycles mid-request → outputs stable and `req_ready`=0 throughout, then the remaining batches resume in order.
- `reset_n` pulsed low during the first of two batches → `out_valid` drops asynchronously, the remaining batch is never emitted, and `rr` restarts at 0.
